// File: rtl/vga_sync_decoder.sv
// Receive-side VGA monitor: samples pin-level hsync/vsync/RGB on pixel enables,
// recovers pixel coordinates, colour and frame boundaries, and tracks timing lock.
module vga_sync_decoder #(
    parameter int H_ACTIVE        = 640,
    parameter int H_SYNC          = 96,
    parameter int H_BP            = 48,
    parameter int H_TOTAL         = 800,
    parameter int V_ACTIVE        = 480,
    parameter int V_SYNC          = 2,
    parameter int V_BP            = 33,
    parameter int V_TOTAL         = 525,
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic        clk_100m,
    input  logic        rstn,
    input  logic        pix_ce,
    input  logic        vga_hsync,
    input  logic        vga_vsync,
    input  logic [3:0]  vga_red,
    input  logic [3:0]  vga_green,
    input  logic [3:0]  vga_blue,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [11:0] meas_h_total,
    output logic [10:0] meas_v_total,
    output logic [7:0]  err_count
);

    localparam logic [11:0] C_H_START     = 12'(H_SYNC + H_BP);
    localparam logic [11:0] C_H_END       = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] C_V_START     = 11'(V_SYNC + V_BP);
    localparam logic [10:0] C_V_END       = 11'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [9:0]  C_PX_X0       = 10'(H_SYNC + H_BP);
    localparam logic [9:0]  C_PX_Y0       = 10'(V_SYNC + V_BP);
    localparam logic [12:0] C_H_TOTAL     = 13'(H_TOTAL);
    localparam logic [11:0] C_V_TOTAL     = 12'(V_TOTAL);
    localparam logic [8:0]  C_LOCK_FRAMES = 9'(LOCK_FRAMES);
    localparam logic [11:0] C_H_MAX       = 12'hFFF;
    localparam logic [10:0] C_V_MAX       = 11'h7FF;
    localparam logic [7:0]  C_ERR_MAX     = 8'hFF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    // Sync edge detection
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_hs_edge;
    logic        w_vs_edge;
    logic        r_hs_prev;
    logic        r_vs_prev;

    // Line / frame measurement
    logic [11:0] r_h_cnt;
    logic [10:0] r_v_cnt;
    logic [12:0] w_h_len;
    logic [11:0] w_v_len;
    logic [11:0] r_meas_h;
    logic [10:0] r_meas_v;
    logic        r_h_ref;
    logic        r_v_ref;
    logic        w_line_err;
    logic        w_frame_len_bad;
    logic        w_frame_err;
    logic        w_frame_clean;
    logic        r_frame_start;

    // Lock FSM
    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_good;
    logic [7:0]  w_good_nxt;
    logic [8:0]  w_good_inc;
    logic        r_ferr;
    logic        w_ferr_nxt;
    logic        r_locked;
    logic        w_locked_nxt;
    logic        w_err_inc;
    logic [7:0]  r_err_count;

    // Pixel recovery
    logic        w_in_h;
    logic        w_in_v;
    logic        w_px_hit;
    logic [9:0]  w_px_x;
    logic [9:0]  w_px_y;
    logic        r_px_valid;
    logic [9:0]  r_px_x;
    logic [9:0]  r_px_y;
    logic [11:0] r_px_rgb;

    assign w_hs_n    = SYNC_ACTIVE_LOW ? ~vga_hsync : vga_hsync;
    assign w_vs_n    = SYNC_ACTIVE_LOW ? ~vga_vsync : vga_vsync;
    assign w_hs_edge = pix_ce & w_hs_n & ~r_hs_prev;
    assign w_vs_edge = pix_ce & w_vs_n & ~r_vs_prev;

    // Lengths are one wider than the counters so a saturated count still reports as too long.
    assign w_h_len = {1'b0, r_h_cnt} + 13'd1;
    assign w_v_len = {1'b0, r_v_cnt} + 12'd1;

    assign w_line_err      = w_hs_edge & r_h_ref & (w_h_len != C_H_TOTAL);
    assign w_frame_len_bad = (w_v_len != C_V_TOTAL);
    assign w_frame_err     = w_vs_edge & r_v_ref & w_frame_len_bad;
    assign w_frame_clean   = ~r_ferr & ~w_line_err & ~w_frame_len_bad;
    assign w_good_inc      = {1'b0, r_good} + 9'd1;

    // Sync history, position counters and line/frame length measurement
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            r_hs_prev     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_h_cnt       <= 12'd0;
            r_v_cnt       <= 11'd0;
            r_meas_h      <= 12'd0;
            r_meas_v      <= 11'd0;
            r_h_ref       <= 1'b0;
            r_v_ref       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_vs_edge;
            if (pix_ce) begin
                r_hs_prev <= w_hs_n;
                r_vs_prev <= w_vs_n;
                if (w_hs_edge) begin
                    r_h_cnt  <= 12'd0;
                    r_meas_h <= w_h_len[12] ? C_H_MAX : w_h_len[11:0];
                    r_h_ref  <= 1'b1;
                end else if (r_h_cnt != C_H_MAX) begin
                    r_h_cnt <= r_h_cnt + 12'd1;
                end
                // A coincident vsync edge restarts the frame and swallows the line increment.
                if (w_vs_edge) begin
                    r_v_cnt  <= 11'd0;
                    r_meas_v <= w_v_len[11] ? C_V_MAX : w_v_len[10:0];
                    r_v_ref  <= 1'b1;
                end else if (w_hs_edge && (r_v_cnt != C_V_MAX)) begin
                    r_v_cnt <= r_v_cnt + 11'd1;
                end
            end
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Lock FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SEARCH: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_MEASURE;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (w_vs_edge && w_frame_clean && (w_good_inc >= C_LOCK_FRAMES)) begin
                    w_state_nxt = ST_LOCKED;
                end else begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (w_line_err || w_frame_err) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_state_nxt = ST_SEARCH;
            end
        endcase
    end

    // Lock FSM outputs: good-frame count, frame-error flag, lock and error strobe
    always_comb begin
        w_good_nxt   = r_good;
        w_ferr_nxt   = r_ferr;
        w_locked_nxt = r_locked;
        w_err_inc    = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                w_locked_nxt = 1'b0;
                if (w_vs_edge) begin
                    w_good_nxt = 8'd0;
                    w_ferr_nxt = 1'b0;
                end else begin
                    w_good_nxt = r_good;
                    w_ferr_nxt = r_ferr;
                end
            end
            ST_MEASURE: begin
                if (w_vs_edge) begin
                    w_good_nxt   = w_frame_clean ? w_good_inc[7:0] : 8'd0;
                    w_ferr_nxt   = 1'b0;
                    w_locked_nxt = (w_state_nxt == ST_LOCKED);
                end else begin
                    w_ferr_nxt   = r_ferr | w_line_err;
                    w_locked_nxt = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (w_line_err || w_frame_err) begin
                    w_locked_nxt = 1'b0;
                    w_err_inc    = 1'b1;
                    w_good_nxt   = 8'd0;
                end else begin
                    w_locked_nxt = 1'b1;
                end
            end
            default: begin
                w_locked_nxt = 1'b0;
                w_good_nxt   = 8'd0;
                w_ferr_nxt   = 1'b0;
            end
        endcase
    end

    // Lock FSM datapath registers and saturating error counter
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            r_good      <= 8'd0;
            r_ferr      <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= 8'd0;
        end else begin
            r_good   <= w_good_nxt;
            r_ferr   <= w_ferr_nxt;
            r_locked <= w_locked_nxt;
            if (w_err_inc && (r_err_count != C_ERR_MAX)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end
    end

    assign w_in_h   = (r_h_cnt >= C_H_START) && (r_h_cnt < C_H_END);
    assign w_in_v   = (r_v_cnt >= C_V_START) && (r_v_cnt < C_V_END);
    assign w_px_hit = pix_ce & r_locked & w_in_h & w_in_v;
    assign w_px_x   = r_h_cnt[9:0] - C_PX_X0;
    assign w_px_y   = r_v_cnt[9:0] - C_PX_Y0;

    // Recovered pixel; coordinates and colour hold while no pixel is being reported
    always_ff @(posedge clk_100m) begin
        if (!rstn) begin
            r_px_valid <= 1'b0;
            r_px_x     <= 10'd0;
            r_px_y     <= 10'd0;
            r_px_rgb   <= 12'd0;
        end else begin
            r_px_valid <= w_px_hit;
            if (w_px_hit) begin
                r_px_x   <= w_px_x;
                r_px_y   <= w_px_y;
                r_px_rgb <= {vga_red, vga_green, vga_blue};
            end
        end
    end

    assign px_valid     = r_px_valid;
    assign px_x         = r_px_x;
    assign px_y         = r_px_y;
    assign px_rgb       = r_px_rgb;
    assign frame_start  = r_frame_start;
    assign locked       = r_locked;
    assign meas_h_total = r_meas_h;
    assign meas_v_total = r_meas_v;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder using a reduced video mode so that
// many whole frames fit in a short run; pixels are checked through a scoreboard.
module tb_vga_sync_decoder;

    localparam int HA = 8;
    localparam int HS = 2;
    localparam int HB = 3;
    localparam int HT = 16;
    localparam int VA = 5;
    localparam int VS = 1;
    localparam int VB = 2;
    localparam int VT = 10;

    logic        clk_100m = 1'b0;
    logic        rstn;
    logic        pix_ce;
    logic        vga_hsync;
    logic        vga_vsync;
    logic [3:0]  vga_red;
    logic [3:0]  vga_green;
    logic [3:0]  vga_blue;
    logic        px_valid;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [11:0] px_rgb;
    logic        frame_start;
    logic        locked;
    logic [11:0] meas_h_total;
    logic [10:0] meas_v_total;
    logic [7:0]  err_count;

    always #5 clk_100m = ~clk_100m;

    vga_sync_decoder #(
        .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)
    ) dut (
        .clk_100m(clk_100m), .rstn(rstn), .pix_ce(pix_ce),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .frame_start(frame_start), .locked(locked),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total),
        .err_count(err_count)
    );

    typedef struct packed {
        logic        v;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] rgb;
    } exp_t;

    typedef struct {
        logic        lk_before;
        logic        lk_after;
        logic        fs;
        logic        fs_next;
        logic [7:0]  err;
        logic [11:0] mh;
        logic [10:0] mv;
    } snap_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic        sb_on;
    logic        ce_at;
    int          n_checks;
    int          n_fail;
    int          pv_count;
    int          first_x, first_y, last_x, last_y;
    snap_t       s, fl, ff, ef;
    logic [65:0] rs_out;
    logic        rs_lk_before;

    // Scoreboard: one expected entry per sample, compared the cycle after the sample
    initial begin
        forever begin
            @(posedge clk_100m);
            ce_at = pix_ce;
            @(negedge clk_100m);
            if (ce_at === 1'b1 && sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                n_checks++;
                if (px_valid !== mon_e.v) begin
                    n_fail++;
                    $display("FAIL px_valid: got %0b expected %0b (x=%0d y=%0d)", px_valid, mon_e.v, mon_e.x, mon_e.y);
                end else if (mon_e.v && (px_x !== mon_e.x || px_y !== mon_e.y || px_rgb !== mon_e.rgb)) begin
                    n_fail++;
                    $display("FAIL pixel: got x=%0d y=%0d rgb=%h expected x=%0d y=%0d rgb=%h",
                             px_x, px_y, px_rgb, mon_e.x, mon_e.y, mon_e.rgb);
                end
            end else if (ce_at !== 1'b1 && sb_on) begin
                n_checks++;
                if (px_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL px_valid_idle: got %0b expected 0 on non-sample cycle", px_valid);
                end
            end
            if (px_valid === 1'b1) begin
                if (pv_count == 0) begin
                    first_x = int'(px_x);
                    first_y = int'(px_y);
                end
                pv_count++;
                last_x = int'(px_x);
                last_y = int'(px_y);
            end
        end
    end

    // One sample occupies four clocks: pix_ce high for the first, then three idle cycles.
    task automatic drive_sample(input logic hs, input logic vs, input logic [11:0] rgb,
                                input logic do_rst, input exp_t e);
        @(posedge clk_100m); #2;
        vga_hsync = ~hs;
        vga_vsync = ~vs;
        {vga_red, vga_green, vga_blue} = rgb;
        pix_ce = 1'b1;
        s.lk_before = locked;
        if (sb_on) sb_q.push_back(e);
        @(posedge clk_100m); #2;
        pix_ce     = 1'b0;
        s.lk_after = locked;
        s.fs       = frame_start;
        s.err      = err_count;
        s.mh       = meas_h_total;
        s.mv       = meas_v_total;
        if (do_rst) rstn = 1'b0;
        @(posedge clk_100m); #2;
        s.fs_next = frame_start;
        if (do_rst) begin
            rs_out = {px_valid, px_x, px_y, px_rgb, frame_start, locked, meas_h_total, meas_v_total, err_count};
            rs_lk_before = s.lk_before;
            rstn = 1'b1;
        end
        @(posedge clk_100m);
    endtask

    // Source pixel p of line l is seen with h_cnt = p-1 and v_cnt = l (p >= 1),
    // because the counters clear on the edge sample itself.
    task automatic drive_line(input int l, input int len, input int rst_pix);
        exp_t        e;
        logic [11:0] rgb;
        int          col, row;
        for (int p = 0; p < len; p++) begin
            rgb   = 12'($urandom_range(0, 4095));
            col   = p - (HS + HB + 1);
            row   = l - (VS + VB);
            e.v   = (col >= 0 && col < HA && row >= 0 && row < VA) ? 1'b1 : 1'b0;
            e.x   = 10'(col);
            e.y   = 10'(row);
            e.rgb = rgb;
            drive_sample((p < HS) ? 1'b1 : 1'b0, (l < VS) ? 1'b1 : 1'b0, rgb,
                         (p == rst_pix) ? 1'b1 : 1'b0, e);
            if (p == 0) fl = s;
        end
    endtask

    task automatic drive_frame(input int n_lines, input int short_line, input int short_len,
                               input int rst_line, input int rst_pix);
        for (int l = 0; l < n_lines; l++) begin
            drive_line(l, (l == short_line) ? short_len : HT, (l == rst_line) ? rst_pix : -1);
            if (l == 0) ff = fl;
            if (l == short_line + 1) ef = fl;
        end
    endtask

    task automatic frame();
        drive_frame(VT, -1, 0, -1, -1);
    endtask

    task automatic pulse_reset();
        @(posedge clk_100m); #2;
        rstn = 1'b0;
        @(posedge clk_100m); #2;
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [65:0] o;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_100m); #2;
            o = {px_valid, px_x, px_y, px_rgb, frame_start, locked, meas_h_total, meas_v_total, err_count};
            n_checks++;
            if (o !== 66'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected 0", o);
            end
            pix_ce    = 1'($urandom_range(0, 1));
            vga_hsync = 1'($urandom_range(0, 1));
            vga_vsync = 1'($urandom_range(0, 1));
        end
        pix_ce    = 1'b0;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        rstn      = 1'b1;
    endtask

    task automatic test_lock();
        frame();
        frame();
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_early: locked=%0b expected 0 before 3rd vsync edge", locked);
        end
        sb_on = 1'b1;
        frame();
        n_checks++;
        if (ff.lk_before !== 1'b0 || ff.lk_after !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_rise: locked before/after 3rd vsync edge = %0b/%0b expected 0/1", ff.lk_before, ff.lk_after);
        end
        n_checks++;
        if (ff.fs !== 1'b1 || ff.fs_next !== 1'b0) begin
            n_fail++;
            $display("FAIL frame_start_pulse: got %0b,%0b expected 1,0", ff.fs, ff.fs_next);
        end
        n_checks++;
        if (ff.mh !== 12'(HT) || ff.mv !== 11'(VT) || ff.err !== 8'd0) begin
            n_fail++;
            $display("FAIL lock_meas: got h=%0d v=%0d err=%0d expected h=%0d v=%0d err=0", ff.mh, ff.mv, ff.err, HT, VT);
        end
    endtask

    task automatic test_pixels();
        pv_count = 0;
        frame();
        n_checks++;
        if (pv_count != HA * VA) begin
            n_fail++;
            $display("FAIL pixel_count: got %0d expected %0d", pv_count, HA * VA);
        end
        n_checks++;
        if (first_x != 0 || first_y != 0 || last_x != HA - 1 || last_y != VA - 1) begin
            n_fail++;
            $display("FAIL pixel_corners: got first=(%0d,%0d) last=(%0d,%0d) expected (0,0) (%0d,%0d)",
                     first_x, first_y, last_x, last_y, HA - 1, VA - 1);
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            frame();
            n_checks++;
            if (locked !== 1'b1 || err_count !== 8'd0 || ff.mv !== 11'(VT) || ff.fs !== 1'b1) begin
                n_fail++;
                $display("FAIL simultaneous_edges: frame %0d locked=%0b err=%0d mv=%0d fs=%0b expected 1,0,%0d,1",
                         f, locked, err_count, ff.mv, ff.fs, VT);
            end
        end
    endtask

    task automatic test_short_line();
        sb_on = 1'b0;
        drive_frame(VT, 5, HT - 1, -1, -1);
        n_checks++;
        if (ef.lk_before !== 1'b1 || ef.lk_after !== 1'b0) begin
            n_fail++;
            $display("FAIL short_line_unlock: locked before/after = %0b/%0b expected 1/0", ef.lk_before, ef.lk_after);
        end
        n_checks++;
        if (ef.err !== 8'd1 || ef.mh !== 12'(HT - 1)) begin
            n_fail++;
            $display("FAIL short_line_meas: got err=%0d mh=%0d expected 1,%0d", ef.err, ef.mh, HT - 1);
        end
        frame();
        frame();
        n_checks++;
        if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL short_line_early_relock: locked=%0b expected 0", locked);
        end
        frame();
        n_checks++;
        if (ff.lk_after !== 1'b1 || ff.err !== 8'd1) begin
            n_fail++;
            $display("FAIL short_line_relock: got locked=%0b err=%0d expected 1,1", ff.lk_after, ff.err);
        end
    endtask

    task automatic test_short_frame();
        pulse_reset();
        frame();
        frame();
        frame();
        n_checks++;
        if (locked !== 1'b1 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL short_frame_prelock: locked=%0b err=%0d expected 1,0", locked, err_count);
        end
        drive_frame(VT - 1, -1, 0, -1, -1);
        frame();
        n_checks++;
        if (ff.lk_before !== 1'b1 || ff.lk_after !== 1'b0 || ff.err !== 8'd1 || ff.mv !== 11'(VT - 1)) begin
            n_fail++;
            $display("FAIL short_frame: got lk %0b->%0b err=%0d mv=%0d expected 1->0 err=1 mv=%0d",
                     ff.lk_before, ff.lk_after, ff.err, ff.mv, VT - 1);
        end
        frame();
        frame();
        frame();
        n_checks++;
        if (ff.lk_after !== 1'b1 || err_count !== 8'd1) begin
            n_fail++;
            $display("FAIL short_frame_relock: got locked=%0b err=%0d expected 1,1", ff.lk_after, err_count);
        end
    endtask

    task automatic test_reset_mid();
        drive_frame(VT, -1, 0, 4, 7);
        n_checks++;
        if (rs_lk_before !== 1'b1 || rs_out !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid: locked before=%0b outputs=%h expected 1 and 0", rs_lk_before, rs_out);
        end
        frame();
        n_checks++;
        if (err_count !== 8'd0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_first_edges: err=%0d locked=%0b expected 0,0", err_count, locked);
        end
        frame();
        frame();
        n_checks++;
        if (ff.lk_after !== 1'b1 || ff.err !== 8'd0 || ff.mh !== 12'(HT)) begin
            n_fail++;
            $display("FAIL reset_mid_relock: locked=%0b err=%0d mh=%0d expected 1,0,%0d", ff.lk_after, ff.err, ff.mh, HT);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pv_count  = 0;
        sb_on     = 1'b0;
        rstn      = 1'b0;
        pix_ce    = 1'b0;
        vga_hsync = 1'b1;
        vga_vsync = 1'b1;
        {vga_red, vga_green, vga_blue} = 12'd0;
        test_reset();
        test_lock();
        test_pixels();
        test_back_to_back();
        test_short_line();
        test_short_frame();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
